// File: rtl/sw_cmd_pkg.sv
// sw_cmd_pkg: constants and helpers shared by the switch command capture block.
//   CMD_W         - width of a command nibble taken from the slide switches
//   DEPTH_DEFAULT - default number of entries in the command FIFO
//   ptr_w()       - read/write pointer width for a given FIFO depth
package sw_cmd_pkg;

    localparam int CMD_W         = 4;
    localparam int DEPTH_DEFAULT = 4;

    // A depth of 1 would give $clog2 == 0; keep at least one pointer bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser followed by an optional debounce filter
// for a single bouncy, asynchronous switch input.
//
// Configuration macro: SW_CMD_DEBOUNCE_EN
//   defined   - level follows the synchronised input only after it has
//               differed from level for DEBOUNCE_CYCLES consecutive cycles
//   undefined - level is the synchronised input; DEBOUNCE_CYCLES is unused
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset
//   raw   in   raw asynchronous switch level
//   level out  synchronised (and filtered) switch level, 0 after reset
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("sw_debounce: DEBOUNCE_CYCLES must be at least 1");
    end

    logic sync_p0;
    logic sync_p1;

    // Stage p0/p1: metastability synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

`ifdef SW_CMD_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             level_p2;

    // Stage p2: filtered level. The counter only runs while the synchronised
    // input disagrees with the accepted level; any agreement restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            level_p2 <= 1'b0;
        end else if (sync_p1 == level_p2) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt      <= '0;
            level_p2 <= sync_p1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign level = level_p2;
`else
    assign level = sync_p1;
`endif

endmodule

// File: rtl/sw_cmd_capture.sv
// sw_cmd_capture: captures a 4-bit command from slide switches each time the
// load switch is raised and queues it in a small FIFO for the control unit.
//
// Configuration macro: SW_CMD_DEBOUNCE_EN (enables the strobe debounce filter
// inside sw_debounce; without it the synchronised strobe is used directly).
//
// Ports:
//   CLOCK_50   in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   sw_data    in   raw command nibble (asynchronous)
//   sw_strobe  in   raw load switch (asynchronous, bouncy)
//   cmd_data   out  command at FIFO head (0 while empty)
//   cmd_valid  out  FIFO non-empty
//   cmd_ready  in   consumer accept; pop on cmd_valid && cmd_ready
//   fifo_count out  occupancy, 0..DEPTH
//   overflow   out  sticky, set when a capture is dropped on a full FIFO
module sw_cmd_capture
    import sw_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DEPTH           = DEPTH_DEFAULT
) (
    input  logic                   CLOCK_50,
    input  logic                   rst,
    input  logic [CMD_W-1:0]       sw_data,
    input  logic                   sw_strobe,
    output logic [CMD_W-1:0]       cmd_data,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sw_cmd_capture: DEPTH must be a power of two, at least 2");
    end

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [CMD_W-1:0] data_p0;
    logic [CMD_W-1:0] data_p1;
    logic             strobe_deb;
    logic             strobe_deb_q;
    logic             rise;

    logic [CMD_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             overflow_q;
    logic             full;
    logic             pop;
    logic             push_ok;

    // Stage p0/p1: data synchroniser, same depth as the strobe path so the
    // nibble is settled by the time the filtered strobe rises.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            data_p0 <= '0;
            data_p1 <= '0;
        end else begin
            data_p0 <= sw_data;
            data_p1 <= data_p0;
        end
    end

    sw_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_strobe (
        .clk  (CLOCK_50),
        .rst  (rst),
        .raw  (sw_strobe),
        .level(strobe_deb)
    );

    // Edge detector; cleared by reset so a strobe held high through reset
    // release is seen as a fresh rising transition.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            strobe_deb_q <= 1'b0;
        end else begin
            strobe_deb_q <= strobe_deb;
        end
    end

    assign rise    = strobe_deb & ~strobe_deb_q;
    assign full    = (count == FULL_CNT);
    assign pop     = cmd_valid & cmd_ready;
    // A full FIFO still accepts when the head leaves on the same edge.
    assign push_ok = rise & (~full | pop);

    // Storage holds no reset: stale words are unreachable once pointers and
    // count are cleared, and cmd_data is gated to 0 while empty.
    always_ff @(posedge CLOCK_50) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_p1;
        end
    end

    // Stage p2: FIFO control
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (rise && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign cmd_valid  = (count != '0);
    assign cmd_data   = cmd_valid ? mem[rd_ptr] : '0;
    assign fifo_count = count;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_sw_cmd_capture.sv
// tb_sw_cmd_capture: scoreboard bench for sw_cmd_capture. Expected commands
// are queued when a strobe is driven and compared as the DUT hands them out.
// Latency and bounce expectations follow SW_CMD_DEBOUNCE_EN.
module tb_sw_cmd_capture;

    localparam int N     = 16;
    localparam int DEPTH = 4;
`ifdef SW_CMD_DEBOUNCE_EN
    localparam int LAT        = N + 3;
    localparam int EXP_BOUNCE = 1;
`else
    localparam int LAT        = 3;
    localparam int EXP_BOUNCE = 8;
`endif
    localparam int HOLD = LAT + 4;

    logic       CLOCK_50;
    logic       rst;
    logic [3:0] sw_data;
    logic       sw_strobe;
    logic [3:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_vec = 0;
    int n_err = 0;
    int n_pop = 0;
    int exp_q[$];

    sw_cmd_capture #(
        .DEBOUNCE_CYCLES(N),
        .DEPTH          (DEPTH)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .rst       (rst),
        .sw_data   (sw_data),
        .sw_strobe (sw_strobe),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "bench timeout");
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    // Inputs are driven at the falling edge; a pop is recorded against the
    // head visible now, since the next rising edge is the one that takes it.
    task automatic tick();
        if (cmd_valid && cmd_ready) begin
            n_pop++;
            check_eq("pop_queued", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check_eq("pop_data", cmd_data, exp_q.pop_front());
            end
        end
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
    endtask

    task automatic send(input int v);
        sw_data   = 4'(v);
        sw_strobe = 1'b1;
        if (exp_q.size() < DEPTH) exp_q.push_back(v);
        repeat (HOLD) tick();
        sw_strobe = 1'b0;
        repeat (HOLD) tick();
    endtask

    task automatic drain();
        int guard;
        guard     = 0;
        cmd_ready = 1'b1;
        while (exp_q.size() != 0 && guard < 64) begin
            tick();
            guard++;
        end
        cmd_ready = 1'b0;
        check_eq("drain_left", exp_q.size(), 0);
        check_eq("drain_valid", cmd_valid, 0);
    endtask

    initial begin
        int start;
        rst       = 1'b1;
        sw_strobe = 1'b1;
        sw_data   = 4'd4;
        cmd_ready = 1'b0;
        @(negedge CLOCK_50);
        repeat (5) tick();
        check_eq("rst_valid", cmd_valid, 0);
        check_eq("rst_count", fifo_count, 0);
        check_eq("rst_ovf", overflow, 0);
        check_eq("rst_data", cmd_data, 0);

        // Strobe already high at release: one push, LAT edges later.
        exp_q.push_back(4);
        rst = 1'b0;
        for (int e = 1; e <= LAT; e++) begin
            tick();
            if (e == LAT - 1) check_eq("lat_early", cmd_valid, 0);
            if (e == LAT)     check_eq("lat_valid", cmd_valid, 1);
        end
        repeat (100 - LAT) tick();
        check_eq("hold_count", fifo_count, 1);
        check_eq("hold_data", cmd_data, 4);
        sw_strobe = 1'b0;
        repeat (HOLD) tick();
        drain();

        // Bouncy strobe: 3-cycle toggling, then stable high.
        sw_data   = 4'd5;
        cmd_ready = 1'b1;
        start     = n_pop;
        repeat (EXP_BOUNCE) exp_q.push_back(5);
        for (int c = 0; c < 40; c++) begin
            sw_strobe = ((c / 3) % 2) == 0;
            tick();
        end
        sw_strobe = 1'b1;
        repeat (HOLD) tick();
        sw_strobe = 1'b0;
        repeat (HOLD) tick();
        check_eq("bounce_pops", n_pop - start, EXP_BOUNCE);
        drain();

        // Overflow: fifth capture dropped, order preserved, flag sticky.
        for (int v = 1; v <= 5; v++) send(v);
        check_eq("ovf_count", fifo_count, 4);
        check_eq("ovf_flag", overflow, 1);
        drain();
        check_eq("ovf_sticky", overflow, 1);

        // Reset mid-operation discards contents.
        for (int v = 6; v <= 8; v++) send(v);
        check_eq("pre_rst_count", fifo_count, 3);
        rst = 1'b1;
        tick();
        exp_q.delete();
        rst = 1'b0;
        check_eq("mid_rst_valid", cmd_valid, 0);
        check_eq("mid_rst_count", fifo_count, 0);
        check_eq("mid_rst_ovf", overflow, 0);
        check_eq("mid_rst_data", cmd_data, 0);
        send(13);
        send(14);
        drain();

        // Full FIFO with a pop on the push edge: both happen.
        for (int v = 8; v <= 11; v++) send(v);
        check_eq("full_count", fifo_count, 4);
        sw_data   = 4'd12;
        sw_strobe = 1'b1;
        exp_q.push_back(12);
        for (int e = 1; e <= LAT; e++) begin
            if (e == LAT) cmd_ready = 1'b1;
            tick();
        end
        cmd_ready = 1'b0;
        check_eq("simul_count", fifo_count, 4);
        check_eq("simul_ovf", overflow, 0);
        sw_strobe = 1'b0;
        repeat (HOLD) tick();
        drain();
        check_eq("final_ovf", overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
